// File: rtl/mouse_master_ctrl_if.sv
// mouse_master_ctrl_if: transmitter/receiver handshake and mouse data bus of the PS/2 mouse host controller
interface mouse_master_ctrl_if;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       BYTE_READY;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_DX;
   logic [7:0] MOUSE_DY;
   logic [7:0] MOUSE_DZ;
   logic       SEND_INTERRUPT;
   logic       INIT_DONE;
   logic       INIT_FAIL;
   logic       WHEEL_MODE;
   logic [3:0] RETRY_COUNT;
   logic [3:0] CURR_STATE;
   modport master (
      output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ,
             SEND_INTERRUPT, INIT_DONE, INIT_FAIL, WHEEL_MODE, RETRY_COUNT, CURR_STATE,
      input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );
   modport slave (
      input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ,
             SEND_INTERRUPT, INIT_DONE, INIT_FAIL, WHEEL_MODE, RETRY_COUNT, CURR_STATE,
      output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );
endinterface

// File: rtl/mouse_master_ctrl.sv
// mouse_master_ctrl: PS/2 mouse host FSM (init script with retries, packet streaming); MOUSE_WHEEL_EN enables IntelliMouse wheel detection
module mouse_master_ctrl #(
   parameter int         INIT_WAIT_CYCLES   = 1000000,
   parameter int         RSP_TIMEOUT_CYCLES = 2000000,
   parameter int         PKT_GAP_CYCLES     = 100000,
   parameter int         MAX_RETRIES        = 3,
   parameter logic [7:0] SAMPLE_RATE        = 8'd100
) (
   input logic CLK,
   input logic RESET,
   mouse_master_ctrl_if.master bus
);
`ifdef MOUSE_WHEEL_EN
   localparam bit WHEEL_EN = 1'b1;
`else
   localparam bit WHEEL_EN = 1'b0;
`endif
   localparam logic [23:0] WAIT_LIM = 24'(INIT_WAIT_CYCLES - 1);
   localparam logic [23:0] RSP_LIM  = 24'(RSP_TIMEOUT_CYCLES - 1);
   localparam logic [23:0] GAP_LIM  = 24'(PKT_GAP_CYCLES - 1);
   typedef enum logic [3:0] {WAIT, SEND, WAIT_SENT, WAIT_RSP, STREAM, IRQ, FAIL} state_t;
   typedef enum logic [1:0] {K_SEND, K_EXP, K_ID, K_END} kind_t;
   typedef struct packed {
      kind_t      k;
      logic [7:0] b;
   } step_t;
   state_t          state_q, state_d;
   logic [23:0]     cnt_q, cnt_d;
   logic [4:0]      step_q, step_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0][7:0] shadow_q, shadow_d;
   logic [3:0][7:0] out_q, out_d;
   logic [3:0]      retry_q, retry_d;
   logic [7:0]      tx_q, tx_d;
   logic            wheel_q, wheel_d;
   logic            send_q, send_d;
   logic            rd_en_q, rd_en_d;
   logic            irq_q, irq_d;
   logic            done_q, done_d;
   logic            fail_q, fail_d;
   logic            clr, init_err, rx_ok, hit;
   logic [1:0]      last;
   step_t           cur, nxt, snd;
   // Init script: base steps, with the wheel knock sequence spliced in after "expect 00"
   function automatic step_t step_at(input logic [4:0] i);
      step_t      s;
      logic [4:0] w, j;
      w = i - 5'd4;
      j = (WHEEL_EN && i >= 5'd19) ? i - 5'd15 : i;
      s.k = K_END;
      s.b = 8'h00;
      if (WHEEL_EN && i >= 5'd4 && i < 5'd19) begin
         s.k = (w == 5'd14) ? K_ID : w[0] ? K_EXP : K_SEND;
         case (w[3:1])
            3'd1:    s.b = 8'hC8;
            3'd3:    s.b = 8'h64;
            3'd5:    s.b = 8'h50;
            3'd6:    s.b = 8'hF2;
            default: s.b = 8'hF3;
         endcase
         if (w[0]) s.b = 8'hFA;
      end else begin
         case (j)
            5'd0: begin s.k = K_SEND; s.b = 8'hFF; end
            5'd1: begin s.k = K_EXP;  s.b = 8'hFA; end
            5'd2: begin s.k = K_EXP;  s.b = 8'hAA; end
            5'd3: begin s.k = K_EXP;  s.b = 8'h00; end
            5'd4: begin s.k = K_SEND; s.b = 8'hF3; end
            5'd5: begin s.k = K_EXP;  s.b = 8'hFA; end
            5'd6: begin s.k = K_SEND; s.b = SAMPLE_RATE; end
            5'd7: begin s.k = K_EXP;  s.b = 8'hFA; end
            5'd8: begin s.k = K_SEND; s.b = 8'hF4; end
            5'd9: begin s.k = K_EXP;  s.b = 8'hFA; end
            default: s.k = K_END;
         endcase
      end
      return s;
   endfunction
   // Next-state, script sequencing, packet assembly and registered-output values
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      retry_d  = retry_q;
      wheel_d  = wheel_q;
      clr      = 1'b0;
      init_err = 1'b0;
      cur      = step_at(step_q);
      nxt      = step_at(step_q + 5'd1);
      rx_ok    = bus.BYTE_ERROR_CODE == 2'b00;
      hit      = (cur.k == K_ID) ? (bus.BYTE_READ == 8'h03 || bus.BYTE_READ == 8'h00) : (bus.BYTE_READ == cur.b);
      last     = wheel_q ? 2'd3 : 2'd2;
      case (state_q)
         WAIT: begin
            if (cnt_q >= WAIT_LIM) begin
               state_d = SEND;
               step_d  = 5'd0;
            end
         end
         SEND: state_d = WAIT_SENT;
         WAIT_SENT: begin
            if (bus.BYTE_SENT) begin
               step_d  = step_q + 5'd1;
               state_d = WAIT_RSP;
            end else if (cnt_q >= RSP_LIM) init_err = 1'b1;
         end
         WAIT_RSP: begin
            if (bus.BYTE_READY && rx_ok && hit) begin
               step_d  = step_q + 5'd1;
               clr     = 1'b1;
               if (cur.k == K_ID) wheel_d = bus.BYTE_READ == 8'h03;
               state_d = (nxt.k == K_SEND) ? SEND : (nxt.k == K_END) ? STREAM : WAIT_RSP;
               if (nxt.k == K_END) begin
                  retry_d = 4'd0;
                  idx_d   = 2'd0;
               end
            end else if (bus.BYTE_READY || cnt_q >= RSP_LIM) init_err = 1'b1;
         end
         STREAM: begin
            if (bus.BYTE_READY && !rx_ok) state_d = WAIT;
            else if (bus.BYTE_READY && (idx_q != 2'd0 || bus.BYTE_READ[3])) begin
               shadow_d[idx_q] = bus.BYTE_READ;
               clr             = 1'b1;
               idx_d           = (idx_q == last) ? 2'd0 : idx_q + 2'd1;
               if (idx_q == last) state_d = IRQ;
            end else if (!bus.BYTE_READY && idx_q != 2'd0 && cnt_q >= GAP_LIM) begin
               idx_d = 2'd0;
               clr   = 1'b1;
            end
         end
         IRQ: begin
            state_d = STREAM;
            idx_d   = 2'd0;
         end
         FAIL:    state_d = FAIL;
         default: state_d = WAIT;
      endcase
      if (init_err) begin
         retry_d = retry_q + 4'd1;
         state_d = (retry_d == 4'(MAX_RETRIES)) ? FAIL : WAIT;
      end
      cnt_d   = (clr || state_d != state_q) ? 24'd0 : cnt_q + {23'd0, ~&cnt_q};
      snd     = step_at(step_d);
      send_d  = state_d == SEND;
      tx_d    = send_d ? snd.b : tx_q;
      rd_en_d = state_d != WAIT && state_d != FAIL;
      irq_d   = state_d == IRQ;
      done_d  = state_d == STREAM || state_d == IRQ;
      fail_d  = state_d == FAIL;
      out_d   = irq_d ? {wheel_q ? shadow_d[3] : 8'h00, shadow_d[2:0]} : out_q;
   end
   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= WAIT;
         cnt_q    <= 24'd0;
         step_q   <= 5'd0;
         idx_q    <= 2'd0;
         shadow_q <= '0;
         out_q    <= '0;
         retry_q  <= 4'd0;
         tx_q     <= 8'hFF;
         wheel_q  <= 1'b0;
         send_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         irq_q    <= 1'b0;
         done_q   <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         retry_q  <= retry_d;
         tx_q     <= tx_d;
         wheel_q  <= wheel_d;
         send_q   <= send_d;
         rd_en_q  <= rd_en_d;
         irq_q    <= irq_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
      end
   end
   assign bus.SEND_BYTE      = send_q;
   assign bus.BYTE_TO_SEND   = tx_q;
   assign bus.READ_ENABLE    = rd_en_q;
   assign bus.MOUSE_STATUS   = out_q[0];
   assign bus.MOUSE_DX       = out_q[1];
   assign bus.MOUSE_DY       = out_q[2];
   assign bus.MOUSE_DZ       = out_q[3];
   assign bus.SEND_INTERRUPT = irq_q;
   assign bus.INIT_DONE      = done_q;
   assign bus.INIT_FAIL      = fail_q;
   assign bus.WHEEL_MODE     = wheel_q;
   assign bus.RETRY_COUNT    = retry_q;
   assign bus.CURR_STATE     = state_q;
endmodule
